// File: rtl/solver_host_link.sv
// Host-side initiator for the solver bank's four-phase ARM link: loads a line group,
// collects one result word per line, then streams image-memory writes.
module solver_host_link #(
  parameter int NUM_LINES = 40,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_data2,
  output logic        arm_val,
  output logic        arm_ack,
  output logic [31:0] arm_data,
  output logic [31:0] arm_data2,
  input  logic        fpga_val,
  input  logic        fpga_ack,
  input  logic [31:0] fpga_data,
  output logic        res_val,
  input  logic        res_rdy,
  output logic [31:0] res_data,
  output logic [5:0]  res_index,
  output logic [1:0]  phase,
  output logic        err,
  output logic [7:0]  stray_cnt
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
  localparam logic [5:0]    LAST_IDX = 6'(NUM_LINES - 1);

  typedef enum logic [3:0] {
    LD_IDLE, LD_VAL, LD_REL,
    RS_WAIT, RS_ACK, RS_REL,
    WR_IDLE, WR_VAL, WR_REL,
    ST_ACK,  ST_REL
  } state_t;

  state_t        state;
  logic          last;
  logic [5:0]    index;
  logic [TW-1:0] tmr;
  logic          res_room;
  logic          capture;
  logic          progress;

  assign res_room = !res_val || res_rdy;
  assign capture  = (state == RS_WAIT) && fpga_val && res_room;

  // Combinational so the source sees the word consumed in the cycle it is offered;
  // a pending stray result in WR_IDLE takes priority over the next write word.
  assign cmd_rdy = reset && cmd_val &&
                   ((state == LD_IDLE) || ((state == WR_IDLE) && !fpga_val));

  // progress = the awaited solver edge arrived (or the state is not a solver wait);
  // a stall caused by downstream backpressure is not charged to the solver.
  always_comb begin
    // NOTE: default assignment first so every path drives progress and no latch is inferred.
    progress = 1'b1;
    case (state)
      LD_VAL, WR_VAL, RS_ACK, ST_ACK: progress = fpga_ack;
      LD_REL, WR_REL, RS_REL, ST_REL: progress = !fpga_ack;
      RS_WAIT:                        progress = capture || !res_room;
      default:                        progress = 1'b1;
    endcase
  end

  // NOTE: all sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LD_IDLE;
      last      <= 1'b0;
      index     <= '0;
      tmr       <= '0;
      arm_val   <= 1'b0;
      arm_ack   <= 1'b0;
      arm_data  <= '0;
      arm_data2 <= '0;
      res_val   <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      phase     <= 2'd0;
      err       <= 1'b0;
      stray_cnt <= '0;
    end else begin
      if (capture)                 res_val <= 1'b1;
      else if (res_val && res_rdy) res_val <= 1'b0;

      case (state)
        LD_IDLE: if (cmd_val) begin
          arm_data  <= cmd_data;
          arm_data2 <= '0;
          arm_val   <= 1'b1;
          last      <= cmd_data[31];
          state     <= LD_VAL;
        end
        LD_VAL, WR_VAL: if (fpga_ack) begin
          arm_val <= 1'b0;
          arm_ack <= 1'b1;
          state   <= (state == LD_VAL) ? LD_REL : WR_REL;
        end
        LD_REL: if (!fpga_ack) begin
          arm_ack <= 1'b0;
          if (last) begin
            state <= RS_WAIT;
            phase <= 2'd1;
            index <= '0;
          end else begin
            state <= LD_IDLE;
          end
        end
        RS_WAIT: if (capture) begin
          res_data  <= fpga_data;
          res_index <= index;
          arm_ack   <= 1'b1;
          state     <= RS_ACK;
        end
        RS_ACK, ST_ACK: if (fpga_ack) begin
          arm_ack <= 1'b0;
          state   <= (state == RS_ACK) ? RS_REL : ST_REL;
        end
        RS_REL: if (!fpga_ack) begin
          index <= index + 6'd1;
          if (index == LAST_IDX) begin
            state <= WR_IDLE;
            phase <= 2'd2;
          end else begin
            state <= RS_WAIT;
          end
        end
        WR_IDLE: begin
          if (fpga_val) begin
            arm_ack <= 1'b1;
            state   <= ST_ACK;
          end else if (cmd_val) begin
            arm_data  <= cmd_data;
            arm_data2 <= cmd_data2;
            arm_val   <= 1'b1;
            last      <= cmd_data[31];
            state     <= WR_VAL;
          end
        end
        WR_REL: if (!fpga_ack) begin
          arm_ack <= 1'b0;
          if (last) begin
            state <= LD_IDLE;
            phase <= 2'd0;
          end else begin
            state <= WR_IDLE;
          end
        end
        ST_REL: if (!fpga_ack) begin
          if (stray_cnt != 8'hFF) stray_cnt <= stray_cnt + 8'd1;
          state <= WR_IDLE;
        end
        default: state <= LD_IDLE;
      endcase

      // Expiry overrides whatever the case above scheduled for this edge.
      if (progress) begin
        tmr <= TMO_LOAD;
      end else if (tmr == TW'(1)) begin
        err     <= 1'b1;
        arm_val <= 1'b0;
        arm_ack <= 1'b0;
        phase   <= 2'd0;
        state   <= LD_IDLE;
        tmr     <= TMO_LOAD;
      end else begin
        tmr <= tmr - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_solver_host_link.sv
// Directed bench for solver_host_link: full load/collect/write cycle with backpressure
// and a stray result, plus a short-timeout instance for expiry and async reset.
module tb_solver_host_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        reset, cmd_val, cmd_rdy, arm_val, arm_ack, fpga_val, fpga_ack;
  logic        res_val, res_rdy, err;
  logic [31:0] cmd_data, cmd_data2, arm_data, arm_data2, fpga_data, res_data;
  logic [5:0]  res_index;
  logic [1:0]  phase;
  logic [7:0]  stray_cnt;

  // short-timeout instance
  logic        t_reset, t_cmd_val, t_cmd_rdy, t_arm_val, t_arm_ack, t_fpga_val, t_fpga_ack;
  logic        t_res_val, t_res_rdy, t_err;
  logic [31:0] t_cmd_data, t_cmd_data2, t_arm_data, t_arm_data2, t_fpga_data, t_res_data;
  logic [5:0]  t_res_index;
  logic [1:0]  t_phase;
  logic [7:0]  t_stray_cnt;

  solver_host_link #(.NUM_LINES(40), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data),
    .cmd_data2(cmd_data2), .arm_val(arm_val), .arm_ack(arm_ack), .arm_data(arm_data),
    .arm_data2(arm_data2), .fpga_val(fpga_val), .fpga_ack(fpga_ack), .fpga_data(fpga_data),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data), .res_index(res_index),
    .phase(phase), .err(err), .stray_cnt(stray_cnt)
  );

  solver_host_link #(.NUM_LINES(40), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset(t_reset), .cmd_val(t_cmd_val), .cmd_rdy(t_cmd_rdy), .cmd_data(t_cmd_data),
    .cmd_data2(t_cmd_data2), .arm_val(t_arm_val), .arm_ack(t_arm_ack), .arm_data(t_arm_data),
    .arm_data2(t_arm_data2), .fpga_val(t_fpga_val), .fpga_ack(t_fpga_ack), .fpga_data(t_fpga_data),
    .res_val(t_res_val), .res_rdy(t_res_rdy), .res_data(t_res_data), .res_index(t_res_index),
    .phase(t_phase), .err(t_err), .stray_cnt(t_stray_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pulse_cnt = 0;
  int          beats = 0, exp_idx = 0, idx_err = 0, overlap = 0, rdy_bad = 0;
  logic [31:0] prev_res = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  always @(posedge arm_val) pulse_cnt++;

  // Protocol invariants and downstream beat order, sampled well between edges.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (arm_val && arm_ack) overlap++;
      if (cmd_rdy && !cmd_val) rdy_bad++;
      if (res_val && res_rdy) begin
        if (32'(res_index) !== exp_idx) idx_err++;
        exp_idx++;
        beats++;
      end
    end
    if (t_reset && t_arm_val && t_arm_ack) overlap++;
  end

  // Offer one command word, then play the solver: ack 2 cycles after arm_val rises.
  task automatic send_cmd(input logic [31:0] d, input logic [31:0] d2,
                          input logic [31:0] exp_d2, input int exp_phase);
    @(negedge clk);
    cmd_val = 1'b1; cmd_data = d; cmd_data2 = d2;
    #1 check("cmd_rdy", 32'(cmd_rdy), 1);
    @(negedge clk);
    cmd_val = 1'b0;
    check("arm_val_rise", 32'(arm_val), 1);
    check("arm_data", arm_data, d);
    check("arm_data2", arm_data2, exp_d2);
    @(negedge clk);
    fpga_ack = 1'b1;
    @(negedge clk);
    check("arm_val_fall", 32'(arm_val), 0);
    check("arm_ack_rise", 32'(arm_ack), 1);
    fpga_ack = 1'b0;
    @(negedge clk);
    check("arm_ack_fall", 32'(arm_ack), 0);
    check("phase_after_word", 32'(phase), exp_phase);
  endtask

  // Present result i; optionally hold it against a blocked downstream for `hold` cycles.
  task automatic give_result(input int i, input int hold);
    logic [31:0] d;
    int acks, moved;
    d = {16'(i + 1), 16'(-i)};
    acks = 0; moved = 0;
    @(negedge clk);
    fpga_val = 1'b1; fpga_data = d;
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (arm_ack) acks++;
        if (res_data !== prev_res) moved++;
      end
      check("bp_no_arm_ack", 32'(acks), 0);
      check("bp_res_data_held", 32'(moved), 0);
      check("bp_res_index_held", 32'(res_index), 32'(i - 1));
      res_rdy = 1'b1;
    end
    @(negedge clk);
    check("res_val", 32'(res_val), 1);
    check("res_data", res_data, d);
    check("res_index", 32'(res_index), 32'(i));
    check("rs_arm_ack", 32'(arm_ack), 1);
    prev_res = d;
    fpga_ack = 1'b1;
    @(negedge clk);
    check("rs_arm_ack_drop", 32'(arm_ack), 0);
    fpga_ack = 1'b0; fpga_val = 1'b0;
    @(negedge clk);
    check("rs_phase", 32'(phase), (i == 39) ? 2 : 1);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0; cmd_val = 1'b0; cmd_data = '0; cmd_data2 = '0;
    fpga_val = 1'b0; fpga_ack = 1'b0; fpga_data = '0; res_rdy = 1'b1;
    t_reset = 1'b0; t_cmd_val = 1'b0; t_cmd_data = '0; t_cmd_data2 = '0;
    t_fpga_val = 1'b0; t_fpga_ack = 1'b0; t_fpga_data = '0; t_res_rdy = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_phase", 32'(phase), 0);
    check("rst_arm_val", 32'(arm_val), 0);
    check("rst_err", 32'(err), 0);
    check("rst_stray_cnt", 32'(stray_cnt), 0);
    check("rst_res_val", 32'(res_val), 0);
    check("rst_arm_data", arm_data, 0);
    reset = 1'b1; t_reset = 1'b1;

    // Load: origin (10,20) then 39 endpoints, last flag on the 40th word.
    for (int j = 0; j < 40; j++) begin
      w = {(j == 39), 13'd0, 9'((j == 0) ? 20 : 100 + j), 9'((j == 0) ? 10 : 3 * j)};
      send_cmd(w, 32'hFFFF_FFFF, 32'h0, (j == 39) ? 1 : 0);
    end
    check("load_arm_val_pulses", 32'(pulse_cnt), 40);

    // Collect, with downstream blocked from result 4 until 50 cycles into result 5.
    for (int i = 0; i < 40; i++) begin
      if (i == 4) res_rdy = 1'b0;
      give_result(i, (i == 5) ? 50 : 0);
    end
    check("res_beats", 32'(beats), 40);
    check("res_index_order", 32'(idx_err), 0);

    // Write phase with one stray result racing the second write word.
    send_cmd({1'b0, 11'd0, 20'h12345}, {16'd7, 16'd100}, 32'h0007_0064, 2);
    @(negedge clk);
    fpga_val = 1'b1; fpga_data = 32'hDEAD_BEEF;
    cmd_val = 1'b1; cmd_data = {1'b0, 11'd0, 20'h0ABCD}; cmd_data2 = {16'd7, 16'd101};
    #1 check("stray_priority_cmd_rdy", 32'(cmd_rdy), 0);
    @(negedge clk);
    check("stray_arm_ack", 32'(arm_ack), 1);
    check("stray_arm_val", 32'(arm_val), 0);
    fpga_ack = 1'b1;
    @(negedge clk);
    check("stray_arm_ack_drop", 32'(arm_ack), 0);
    fpga_ack = 1'b0; fpga_val = 1'b0; cmd_val = 1'b0;
    @(negedge clk);
    check("stray_cnt", 32'(stray_cnt), 1);
    check("stray_res_val", 32'(res_val), 0);
    send_cmd({1'b0, 11'd0, 20'h0ABCD}, {16'd7, 16'd101}, {16'd7, 16'd101}, 2);
    send_cmd({1'b1, 11'd0, 20'h54321}, {16'd7, 16'd102}, {16'd7, 16'd102}, 0);
    check("write_arm_val_pulses", 32'(pulse_cnt), 43);
    check("stray_res_untouched", 32'(beats), 40);

    // Timeout: solver never acks; expiry lands on the 16th wait cycle.
    @(negedge clk);
    t_cmd_val = 1'b1; t_cmd_data = 32'h0000_1234;
    @(negedge clk);
    t_cmd_val = 1'b0;
    check("to_arm_val", 32'(t_arm_val), 1);
    repeat (15) @(negedge clk);
    check("to_err_early", 32'(t_err), 0);
    check("to_arm_val_held", 32'(t_arm_val), 1);
    @(negedge clk);
    check("to_err", 32'(t_err), 1);
    check("to_arm_val_drop", 32'(t_arm_val), 0);
    check("to_arm_ack", 32'(t_arm_ack), 0);
    check("to_phase", 32'(t_phase), 0);
    t_cmd_val = 1'b1; t_cmd_data = 32'h0000_5678;
    #1 check("to_back_in_ld_idle", 32'(t_cmd_rdy), 1);

    // Async reset mid-load clears every output without waiting for a clock edge.
    @(negedge clk);
    check("to_reload_arm_val", 32'(t_arm_val), 1);
    #2 t_reset = 1'b0;
    #1;
    check("arst_err", 32'(t_err), 0);
    check("arst_arm_val", 32'(t_arm_val), 0);
    check("arst_cmd_rdy", 32'(t_cmd_rdy), 0);
    check("arst_all_zero", 32'(|{t_cmd_rdy, t_arm_val, t_arm_ack, t_arm_data, t_arm_data2,
                                 t_res_val, t_res_data, t_res_index, t_phase, t_err,
                                 t_stray_cnt}), 0);
    @(negedge clk);
    t_cmd_val = 1'b0; t_reset = 1'b1;

    check("arm_val_ack_overlap", 32'(overlap), 0);
    check("cmd_rdy_without_val", 32'(rdy_bad), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
